// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - core data bus bundle for the MMIO UART transmitter
interface mmio_uart_tx_if;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [2:0]  bus_format;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [31:0] bus_read_data;

  modport master (
    output bus_address, bus_write_data, bus_format, bus_read_enable, bus_write_enable,
    input  bus_read_data
  );

  modport slave (
    input  bus_address, bus_write_data, bus_format, bus_read_enable, bus_write_enable,
    output bus_read_data
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - MMIO UART transmitter (TXDATA/STATUS), 8N1, LSB first
// Optional FIFO queue enabled with `define UART_TX_FIFO_EN; otherwise a single holding register.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_2000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic           clock,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           uart_tx
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_overflow;

  logic       w_sel;
  logic       w_wr_txdata;
  logic       w_wr_status;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_busy;
  logic       w_baud_done;
  logic [7:0] w_head;
  logic       w_unused;

  assign w_sel       = (bus.bus_address[31:3] == BASE_ADDRESS[31:3]);
  assign w_wr_txdata = w_sel && bus.bus_write_enable && !bus.bus_address[2];
  assign w_wr_status = w_sel && bus.bus_write_enable &&  bus.bus_address[2];
  assign w_push      = w_wr_txdata && !w_full;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_busy      = (r_state != S_IDLE);
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign w_unused    = ^{bus.bus_format, bus.bus_address[1:0], bus.bus_write_data[31:8]};

`ifdef UART_TX_FIFO_EN
  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;

  assign w_head  = r_mem[r_rptr];
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= bus.bus_write_data[7:0];
  end
`else
  logic [7:0] r_hold;
  logic       r_hold_valid;

  assign w_head  = r_hold;
  assign w_empty = !r_hold_valid;
  assign w_full  = r_hold_valid;

  // Push needs an empty holder and pop a full one, so they never coincide.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_push) begin
      r_hold       <= bus.bus_write_data[7:0];
      r_hold_valid <= 1'b1;
    end else if (w_pop) begin
      r_hold_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_wr_txdata && w_full) begin
      r_overflow <= 1'b1;
    end else if (w_wr_status) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next_state = S_START;
      S_START: if (w_baud_done) w_next_state = S_DATA;
      S_DATA:  if (w_baud_done && (r_bit == 3'd7)) w_next_state = S_STOP;
      S_STOP:  if (w_baud_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    case (r_state)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = r_shift[0];
      default: uart_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_bit   <= '0;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
          end else begin
            r_baud  <= r_baud + 1'b1;
          end
        end
        default: r_baud <= w_baud_done ? '0 : r_baud + 1'b1;
      endcase
    end
  end

  always_comb begin
    bus.bus_read_data = '0;
    if (w_sel && bus.bus_read_enable && bus.bus_address[2]) begin
      bus.bus_read_data = {28'b0, r_overflow, w_empty, w_full, w_busy};
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx against a frame-timer model
module tb_mmio_uart_tx;
  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h0000_2000;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic clock = 1'b0;
  logic reset;
  logic uart_tx;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(
    .BASE_ADDRESS (BASE),
    .CLKS_PER_BIT (N),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus_if),
    .uart_tx (uart_tx)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model: pending byte queue plus a frame timer counting down the cycles left in the frame.
  logic [7:0]  m_q[$];
  int          m_rem;
  logic [7:0]  m_cur;
  bit          m_ovf;
  logic [31:0] rd_act;
  logic [31:0] rd_exp;

  function automatic logic [31:0] m_status();
    return {28'b0, m_ovf, (m_q.size() == 0), (m_q.size() == DEPTH), (m_rem != 0)};
  endfunction

  function automatic logic m_line();
    int idx;
    if (m_rem == 0) return 1'b1;
    idx = (10 * N - m_rem) / N;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_cur[idx-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] addr, input bit re);
    if (re && (addr[31:3] == BASE[31:3]) && addr[2]) return m_status();
    return 32'h0;
  endfunction

  task automatic tick(input bit rst, input bit we, input bit re,
                      input logic [31:0] addr, input logic [31:0] data);
    bit sel;
    bit full_pre;
    reset                   = rst;
    bus_if.bus_address      = addr;
    bus_if.bus_write_data   = data;
    bus_if.bus_format       = 3'($urandom);
    bus_if.bus_read_enable  = re;
    bus_if.bus_write_enable = we;
    #1;
    rd_act = bus_if.bus_read_data;
    rd_exp = m_read(addr, re);
    @(posedge clock);
    sel      = (addr[31:3] == BASE[31:3]);
    full_pre = (m_q.size() == DEPTH);
    if (rst) begin
      m_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
      m_cur = 8'h0;
    end else begin
      if (m_rem == 0 && m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_rem = 10 * N;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (we && sel && !addr[2]) begin
        if (full_pre) m_ovf = 1'b1;
        else          m_q.push_back(data[7:0]);
      end
      if (we && sel && addr[2]) m_ovf = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, BASE, 0);
    tick(1, 1, 0, BASE, 32'h12);
    tests++;
    if (uart_tx !== 1'b1) begin fails++; $display("FAIL reset_line: got %b want 1", uart_tx); end
    tick(0, 0, 1, BASE + 4, 0);
    tests++;
    if (rd_act !== 32'h4) begin fails++; $display("FAIL reset_status: got %h want 00000004", rd_act); end
    tick(0, 0, 1, BASE, 0);
    tests++;
    if (rd_act !== 32'h0) begin fails++; $display("FAIL read_txdata: got %h want 0", rd_act); end
    tick(0, 0, 1, BASE + 8, 0);
    tests++;
    if (rd_act !== 32'h0) begin fails++; $display("FAIL read_unmapped: got %h want 0", rd_act); end
    tick(0, 0, 0, BASE + 4, 0);
    tests++;
    if (rd_act !== 32'h0) begin fails++; $display("FAIL read_no_enable: got %h want 0", rd_act); end
    tick(0, 0, 1, BASE + 5, 0);
    tests++;
    if (rd_act !== 32'h4) begin fails++; $display("FAIL status_low_bits: got %h want 00000004", rd_act); end
  endtask

  task automatic test_frame_55();
    int busy_cycles = 0;
    tick(0, 1, 0, BASE, 32'hDEAD_BE55);
    for (int i = 0; i < 50; i++) begin
      tick(0, 0, 1, BASE + 4, 0);
      if (rd_act[0]) busy_cycles++;
      tests++;
      if (rd_act !== rd_exp) begin fails++; $display("FAIL frame55_status c%0d: got %h want %h", i, rd_act, rd_exp); end
      tests++;
      if (uart_tx !== m_line()) begin fails++; $display("FAIL frame55_line c%0d: got %b want %b", i, uart_tx, m_line()); end
    end
    tests++;
    if (busy_cycles != 40) begin fails++; $display("FAIL frame55_busy_len: got %0d want 40", busy_cycles); end
  endtask

  task automatic test_overflow();
    logic [31:0] w_addr [3] = '{BASE, BASE + 1, BASE + 3};
    logic [7:0]  w_data [3] = '{8'hA5, 8'h3C, 8'h77};
    int          w_when [3] = '{0, 2, 20};
    int          k = 0;
    for (int c = 0; c < 110; c++) begin
      if (k < 3 && c == w_when[k]) begin
        tick(0, 1, 1, w_addr[k], {24'h0, w_data[k]});
        k++;
      end else begin
        tick(0, 0, 1, BASE + 4, 0);
      end
      tests++;
      if (uart_tx !== m_line()) begin fails++; $display("FAIL ovf_line c%0d: got %b want %b", c, uart_tx, m_line()); end
      tests++;
      if (rd_act !== rd_exp) begin fails++; $display("FAIL ovf_status c%0d: got %h want %h", c, rd_act, rd_exp); end
    end
    tick(0, 0, 1, BASE + 4, 0);
`ifndef UART_TX_FIFO_EN
    tests++;
    if (rd_act[3] !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", rd_act[3]); end
`endif
    tick(0, 1, 0, BASE + 4, 32'hFFFF_FFFF);
    tick(0, 0, 1, BASE + 4, 0);
    tests++;
    if (rd_act[3] !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b want 0", rd_act[3]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 6; i++) begin
      tick(0, 1, 0, BASE, i);
      tests++;
      if (uart_tx !== m_line()) begin fails++; $display("FAIL b2b_line w%0d: got %b want %b", i, uart_tx, m_line()); end
    end
    tick(0, 0, 1, BASE + 4, 0);
    tests++;
    if (rd_act !== 32'hB) begin fails++; $display("FAIL b2b_status: got %h want 0000000b", rd_act); end
    for (int c = 0; c < 240; c++) begin
      tick(0, 0, 1, BASE + 4, 0);
      tests++;
      if (uart_tx !== m_line()) begin fails++; $display("FAIL b2b_line c%0d: got %b want %b", c, uart_tx, m_line()); end
      tests++;
      if (rd_act !== rd_exp) begin fails++; $display("FAIL b2b_status c%0d: got %h want %h", c, rd_act, rd_exp); end
    end
    tick(0, 1, 0, BASE + 4, 0);
  endtask

  task automatic test_reset_mid_frame();
    tick(0, 1, 0, BASE, 32'hFF);
    for (int c = 0; c < 1 + N + 3 * N; c++) tick(0, 0, 0, BASE, 0);
    tests++;
    if (m_line() !== uart_tx) begin fails++; $display("FAIL midrst_pre: got %b want %b", uart_tx, m_line()); end
    tick(0, 1, 0, BASE, 32'h00);
    tick(1, 1, 0, BASE, 32'h00);
    tick(0, 0, 1, BASE + 4, 0);
    tests++;
    if (uart_tx !== 1'b1) begin fails++; $display("FAIL midrst_line: got %b want 1", uart_tx); end
    tests++;
    if (rd_act !== 32'h4) begin fails++; $display("FAIL midrst_status: got %h want 00000004", rd_act); end
    for (int c = 0; c < 60; c++) begin
      tick(0, 0, 0, BASE, 0);
      tests++;
      if (uart_tx !== 1'b1) begin fails++; $display("FAIL midrst_quiet c%0d: got %b want 1", c, uart_tx); end
    end
  endtask

  task automatic test_random();
    logic [31:0] addrs [6] = '{BASE, BASE + 4, BASE + 8, BASE + 2, BASE + 7, 32'h0000_3000};
    logic [31:0] a;
    bit          we;
    bit          re;
    for (int c = 0; c < 1200; c++) begin
      a  = addrs[$urandom_range(0, 5)];
      we = ($urandom_range(0, 15) == 0);
      re = $urandom_range(0, 1) == 1;
      tick(0, we, re, a, $urandom);
      tests++;
      if (uart_tx !== m_line()) begin fails++; $display("FAIL rand_line c%0d: got %b want %b", c, uart_tx, m_line()); end
      tests++;
      if (rd_act !== rd_exp) begin fails++; $display("FAIL rand_read c%0d addr %h: got %h want %h", c, a, rd_act, rd_exp); end
    end
  endtask

  initial begin
    m_rem = 0;
    m_ovf = 1'b0;
    m_cur = 8'h0;
    test_reset();
    test_frame_55();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
